leaf_port_stream_fifo: RTL

// - Elastic buffer on one user->interface output port of a leaf: sits between a user kernel's
//   din_leaf_user2interface_k / vld / ack port and the matching leaf_interface input.
// - Decouples kernel bursts from BFT back-pressure and exposes occupancy and a sent-word count
//   for leaf-level debug and throughput measurement.

---
 rtl/leaf_pkg.sv | 16 +
 rtl/leaf_port_stream_fifo_if.sv | 23 ++
 rtl/leaf_sdp_ram.sv | 24 ++
 rtl/leaf_port_stream_fifo.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/leaf_pkg.sv
// Shared leaf-level definitions: payload/packet field widths and the
// output-stage state encoding of the port stream FIFO.
package leaf_pkg;

  localparam int PAYLOAD_BITS  = 32;
  localparam int PACKET_BITS   = 49;
  localparam int NUM_LEAF_BITS = 5;
  localparam int NUM_PORT_BITS = 4;
  localparam int NUM_ADDR_BITS = 7;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

endpackage

// File: rtl/leaf_port_stream_fifo_if.sv
// Stream handshake bundle for one user->interface leaf port.
// The FIFO takes the slave view; the kernel/interface side takes the master view.
interface leaf_port_stream_fifo_if;
  import leaf_pkg::*;

  logic [PAYLOAD_BITS-1:0] din_user;
  logic                    vld_user;
  logic                    ack_user;
  logic [PAYLOAD_BITS-1:0] dout_if;
  logic                    vld_if;
  logic                    ack_if;

  modport slave (
    input  din_user, vld_user, ack_if,
    output ack_user, dout_if, vld_if
  );

  modport master (
    output din_user, vld_user, ack_if,
    input  ack_user, dout_if, vld_if
  );

endinterface

// File: rtl/leaf_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset
// on storage. A write to the address being read returns the new word so the
// FIFO head is always current one cycle after its address is presented.
module leaf_sdp_ram #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [DATA_BITS-1:0] o_rd_data
);

  logic [DATA_BITS-1:0] r_mem [0:(2**ADDR_BITS)-1];

  // Write storage and register the read word (write-first on address match)
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= (i_we && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];
  end

endmodule

// File: rtl/leaf_port_stream_fifo.sv
// Elastic FWFT buffer between a user kernel output port and leaf_interface.
// The output register counts as one storage slot; the RAM holds the rest.
// All outputs are registered; occupancy and delivered-word count are exported.
module leaf_port_stream_fifo
  import leaf_pkg::*;
#(
  parameter int DEPTH_BITS   = 5,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                     clk_user,
  input  logic                     reset_n,
  input  logic                     clear,
  leaf_port_stream_fifo_if.slave   port,
  output logic [DEPTH_BITS:0]      count,
  output logic                     almost_full,
  output logic [31:0]              words_sent
);

  localparam int                  DEPTH     = 2**DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT  = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AFULL_CNT = (DEPTH_BITS+1)'(DEPTH - AFULL_MARGIN);

  out_state_t              r_state;
  logic [PAYLOAD_BITS-1:0] r_dout;
  logic                    r_vld;
  logic                    r_ack_user;
  logic                    r_afull;
  logic [DEPTH_BITS-1:0]   r_wr_ptr;
  logic [DEPTH_BITS-1:0]   r_rd_ptr;
  logic [DEPTH_BITS:0]     r_count;
  logic [31:0]             r_words_sent;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_out_free;
  logic [DEPTH_BITS:0]     w_ram_cnt;
  logic                    w_ram_nonempty;
  logic                    w_load_ram;
  logic                    w_load_in;
  logic                    w_ram_we;
  logic [DEPTH_BITS-1:0]   w_rd_ptr_next;
  logic [DEPTH_BITS:0]     w_count_next;
  logic [PAYLOAD_BITS-1:0] w_ram_q;

  // Handshakes; clear suppresses any storage side effect of a push
  assign w_push         = port.vld_user & r_ack_user;
  assign w_pop          = r_vld & port.ack_if;
  assign w_out_free     = ~r_vld | w_pop;
  assign w_ram_cnt      = r_count - {{DEPTH_BITS{1'b0}}, r_vld};
  assign w_ram_nonempty = (w_ram_cnt != '0);
  // RAM words have priority over the incoming word to keep strict ordering
  assign w_load_ram     = w_out_free & w_ram_nonempty;
  assign w_load_in      = w_out_free & ~w_ram_nonempty & w_push;
  assign w_ram_we       = w_push & ~w_load_in & ~clear;
  assign w_rd_ptr_next  = clear ? '0 : (r_rd_ptr + DEPTH_BITS'(w_load_ram));

  // Occupancy after this edge: push and pop together leave it unchanged
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + (DEPTH_BITS+1)'(1);
    else if (!w_push && w_pop) w_count_next = r_count - (DEPTH_BITS+1)'(1);
    if (clear)                 w_count_next = '0;
  end

  // Read address runs one step ahead so w_ram_q is the head word for the next edge
  leaf_sdp_ram #(
    .ADDR_BITS (DEPTH_BITS),
    .DATA_BITS (PAYLOAD_BITS)
  ) u_ram (
    .i_clk     (clk_user),
    .i_we      (w_ram_we),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (port.din_user),
    .i_rd_addr (w_rd_ptr_next),
    .o_rd_data (w_ram_q)
  );

  // Output-stage FSM with pointers, occupancy, status flags and sent-word counter
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= OUT_EMPTY;
      r_dout       <= '0;
      r_vld        <= 1'b0;
      r_ack_user   <= 1'b0;
      r_afull      <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_words_sent <= '0;
    end else if (clear) begin
      r_state      <= OUT_EMPTY;
      r_vld        <= 1'b0;
      r_ack_user   <= 1'b1;
      r_afull      <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_words_sent <= '0;
    end else begin
      r_count    <= w_count_next;
      r_ack_user <= (w_count_next < FULL_CNT);
      r_afull    <= (w_count_next >= AFULL_CNT);
      r_rd_ptr   <= w_rd_ptr_next;
      if (w_ram_we) r_wr_ptr     <= r_wr_ptr + DEPTH_BITS'(1);
      if (w_pop)    r_words_sent <= r_words_sent + 32'd1;
      case (r_state)
        OUT_EMPTY: begin
          if (w_load_ram) begin
            r_dout  <= w_ram_q;
            r_vld   <= 1'b1;
            r_state <= OUT_VALID;
          end else if (w_load_in) begin
            r_dout  <= port.din_user;
            r_vld   <= 1'b1;
            r_state <= OUT_VALID;
          end
        end
        OUT_VALID: begin
          if (w_pop) begin
            if (w_load_ram) begin
              r_dout <= w_ram_q;
            end else if (w_load_in) begin
              r_dout <= port.din_user;
            end else begin
              r_vld   <= 1'b0;
              r_state <= OUT_EMPTY;
            end
          end
        end
        default: begin
          r_vld   <= 1'b0;
          r_state <= OUT_EMPTY;
        end
      endcase
    end
  end

  assign port.ack_user = r_ack_user;
  assign port.dout_if  = r_dout;
  assign port.vld_if   = r_vld;
  assign count         = r_count;
  assign almost_full   = r_afull;
  assign words_sent    = r_words_sent;

endmodule
